// File: rtl/fetch_pkg.sv
// Shared types and helpers for the RV32IC fetch aligner.
package fetch_pkg;

  typedef enum logic {EMPTY, HALF} fetch_state_t;

  localparam logic [15:0] C_ILLEGAL = 16'h0000;

  function automatic logic is_compressed(input logic [15:0] h);
    return h[1:0] != 2'b11;
  endfunction

endpackage

// File: rtl/fetch_aligner.sv
// Fetch aligner: word reads from program memory, one aligned RV32IC instruction per handshake, flush on redirect.
// Outputs are combinational from state and mem_rdata; FETCH_ILLEGAL_CHK_EN adds the instr_illegal flag.
module fetch_aligner
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_compressed,
`ifdef FETCH_ILLEGAL_CHK_EN
  output logic              instr_illegal,
`endif
  output logic              instr_valid,
  input  logic              instr_ready
);

  fetch_state_t      r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_pc, w_pc_nxt;
  logic [15:0]       r_hbuf, w_hbuf_nxt;
  logic [ADDR_W-1:0] w_base;
  logic              w_valid;
  logic              w_take;

  assign w_base   = {r_pc[ADDR_W-1:2], 2'b00};
  assign mem_addr = (r_state == HALF) ? w_base + ADDR_W'(4) : w_base;
  assign instr_pc = r_pc;
  assign w_take   = w_valid & instr_ready;

  always_comb begin
    w_valid          = 1'b0;
    instr            = '0;
    instr_compressed = 1'b0;
    w_pc_nxt         = r_pc;
    w_hbuf_nxt       = r_hbuf;
    w_state_nxt      = r_state;

    if (r_state == EMPTY) begin
      if (!r_pc[1]) begin
        w_valid = 1'b1;
        if (is_compressed(mem_rdata[15:0])) begin
          instr            = {16'h0000, mem_rdata[15:0]};
          instr_compressed = 1'b1;
          if (w_take) begin
            w_pc_nxt    = r_pc + ADDR_W'(2);
            w_hbuf_nxt  = mem_rdata[31:16];
            w_state_nxt = HALF;
          end
        end else begin
          instr = mem_rdata;
          if (w_take) w_pc_nxt = r_pc + ADDR_W'(4);
        end
      end else if (is_compressed(mem_rdata[31:16])) begin
        w_valid          = 1'b1;
        instr            = {16'h0000, mem_rdata[31:16]};
        instr_compressed = 1'b1;
        if (w_take) w_pc_nxt = r_pc + ADDR_W'(2);
      end else begin
        // Odd entry into a 32-bit instruction: capture the low half, no ready needed.
        w_hbuf_nxt  = mem_rdata[31:16];
        w_state_nxt = HALF;
      end
    end else begin
      w_valid = 1'b1;
      if (is_compressed(r_hbuf)) begin
        instr            = {16'h0000, r_hbuf};
        instr_compressed = 1'b1;
        if (w_take) begin
          w_pc_nxt    = r_pc + ADDR_W'(2);
          w_state_nxt = EMPTY;
        end
      end else begin
        instr = {mem_rdata[15:0], r_hbuf};
        if (w_take) begin
          w_pc_nxt   = r_pc + ADDR_W'(4);
          w_hbuf_nxt = mem_rdata[31:16];
        end
      end
    end

    if (redirect) begin
      w_valid     = 1'b0;
      w_pc_nxt    = redirect_pc & ~ADDR_W'(1);
      w_hbuf_nxt  = r_hbuf;
      w_state_nxt = EMPTY;
    end
  end

  // Reset gates valid directly so nothing is offered while reset is held.
  assign instr_valid = w_valid & reset_n;

`ifdef FETCH_ILLEGAL_CHK_EN
  assign instr_illegal = instr_valid &
                         (instr_compressed ? (instr[15:0] == C_ILLEGAL) : (instr == 32'hFFFF_FFFF));
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= EMPTY;
      r_pc    <= RESET_PC;
      r_hbuf  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_hbuf  <= w_hbuf_nxt;
    end
  end

endmodule

// File: tb/tb_fetch_aligner.sv
// Directed bench for fetch_aligner with a scoreboard of expected transfers.
module tb_fetch_aligner;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
    logic        c;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_compressed;
  logic        instr_valid;
  logic        instr_ready;
`ifdef FETCH_ILLEGAL_CHK_EN
  logic        instr_illegal;
`endif

  logic [31:0] mem [0:1023];
  exp_t        sb [$];
  int          n_chk  = 0;
  int          n_pass = 0;

  assign mem_rdata = mem[mem_addr[11:2]];

  fetch_aligner #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .mem_addr         (mem_addr),
    .mem_rdata        (mem_rdata),
    .redirect         (redirect),
    .redirect_pc      (redirect_pc),
    .instr            (instr),
    .instr_pc         (instr_pc),
    .instr_compressed (instr_compressed),
`ifdef FETCH_ILLEGAL_CHK_EN
    .instr_illegal    (instr_illegal),
`endif
    .instr_valid      (instr_valid),
    .instr_ready      (instr_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  always @(negedge clk) begin
    if (reset_n && instr_valid && instr_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_xfer", {instr_pc, instr, instr_compressed}, '1);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("xfer", {instr_pc, instr, instr_compressed}, e);
      end
    end
  end

  task automatic push(input logic [31:0] pc, input logic [31:0] ins, input logic c);
    exp_t e;
    e.pc = pc; e.ins = ins; e.c = c;
    sb.push_back(e);
  endtask

  // Called at posedge+1; runs with ready=1 until every expected transfer has been seen.
  task automatic drain(input string tag, input int exp_cycles);
    int cyc = 0;
    instr_ready = 1'b1;
    while (sb.size() != 0 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    instr_ready = 1'b0;
    chk({tag, "_drained"}, sb.size(), 0);
    chk({tag, "_cycles"}, cyc, exp_cycles);
  endtask

  task automatic do_redirect(input logic [31:0] pc);
    redirect    = 1'b1;
    redirect_pc = pc;
    #1 chk("redirect_valid_low", instr_valid, 1'b0);
    @(posedge clk); #1;
    redirect = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0000_0000;
    mem[0]     = 32'h0020_0093;
    mem[1]     = 32'h0593_4529;
    mem[2]     = 32'h0050_0050;
    mem[4]     = 32'h458d_9506;
    mem[5]     = 32'hDEAD_BEEF;
    mem[8]     = 32'h0713_1234;
    mem[9]     = 32'h8311_fff0;
    mem[12]    = 32'h0000_0013;
    mem[10'h3FF] = 32'h00B3_5555;

    reset_n     = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    instr_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid", instr_valid, 1'b0);
    chk("reset_addr", mem_addr, 32'h0);
    reset_n = 1'b1;

    // Mixed 32/16/straddling stream from reset.
    push(32'h0, 32'h0020_0093, 1'b0);
    push(32'h4, 32'h0000_4529, 1'b1);
    push(32'h6, 32'h0050_0593, 1'b0);
    drain("stream", 3);

    // Stall in HALF with the buffered compressed half at 0xA.
    for (int i = 0; i < 3; i++) begin
      chk("stall_hold", {instr_valid, instr, instr_pc, mem_addr},
          {1'b1, 32'h0000_0050, 32'h0000_000A, 32'h0000_000C});
      @(posedge clk); #1;
    end
    push(32'hA, 32'h0000_0050, 1'b1);
    drain("stall_release", 1);

    // Two compressed halves from one word.
    push(32'h10, 32'h0000_9506, 1'b1);
    push(32'h12, 32'h0000_458d, 1'b1);
    do_redirect(32'h10);
    drain("two_c", 2);

    // Odd redirect into a straddling 32-bit instruction: one bubble.
    push(32'h22, 32'hfff0_0713, 1'b0);
    push(32'h26, 32'h0000_8311, 1'b1);
    do_redirect(32'h23);
    drain("odd_redirect", 3);

    // Redirect while HALF holds a buffered half, with ready already high.
    push(32'h10, 32'h0000_9506, 1'b1);
    do_redirect(32'h10);
    drain("pre_half", 1);
    push(32'h30, 32'h0000_0013, 1'b0);
    instr_ready = 1'b1;
    do_redirect(32'h30);
    drain("redirect_in_half", 1);

    // Straddle across the top of the address space.
    push(32'hFFFF_FFFE, 32'h0093_00B3, 1'b0);
    push(32'h0000_0002, 32'h0000_0020, 1'b1);
    do_redirect(32'hFFFF_FFFE);
    drain("wrap", 3);

    // Reset in the middle of a cycle, then restart from RESET_PC.
    chk("pre_reset_valid", instr_valid, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    chk("midreset_valid", instr_valid, 1'b0);
    chk("midreset_addr", mem_addr, 32'h0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    push(32'h0, 32'h0020_0093, 1'b0);
    push(32'h4, 32'h0000_4529, 1'b1);
    push(32'h6, 32'h0050_0593, 1'b0);
    drain("restart", 3);

`ifdef FETCH_ILLEGAL_CHK_EN
    mem[31] = 32'h0000_0000;
    do_redirect(32'h7C);
    chk("illegal", {instr_valid, instr_pc, instr, instr_compressed, instr_illegal},
        {1'b1, 32'h7C, 32'h0, 1'b1, 1'b1});
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
